// File: rtl/mem_pkg.sv
// Shared types and default address map for the memory controller.
package mem_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_STROBE = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  typedef enum logic [1:0] {
    TGT_RAM1,
    TGT_RAM2,
    TGT_UART_DATA,
    TGT_UART_STAT
  } target_t;

  localparam logic [15:0] DEF_RAM2_TOP  = 16'hBEFF;
  localparam logic [15:0] DEF_UART_BASE = 16'hBF00;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address-to-target decode.
// With MEM_CTRL_UART_EN undefined the UART registers fall through to RAM1.
module mem_addr_decode import mem_pkg::*; #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RAM2_TOP  = ADDR_W'(DEF_RAM2_TOP),
  parameter logic [ADDR_W-1:0] UART_BASE = ADDR_W'(DEF_UART_BASE)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output target_t           target_o
);

`ifdef MEM_CTRL_UART_EN
  always_comb begin
    if (addr_i <= RAM2_TOP)
      target_o = TGT_RAM2;
    else if (addr_i == UART_BASE)
      target_o = TGT_UART_DATA;
    else if (addr_i == UART_BASE + ADDR_W'(1))
      target_o = TGT_UART_STAT;
    else
      target_o = TGT_RAM1;
  end
`else
  logic unused_base;
  assign unused_base = ^UART_BASE;
  assign target_o = (addr_i <= RAM2_TOP) ? TGT_RAM2 : TGT_RAM1;
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Sequenced CPU access to two async SRAMs (and a UART when MEM_CTRL_UART_EN is defined).
// Each access walks SETUP -> STROBE -> HOLD(WAIT_CYC cycles) -> DONE.
module mem_ctrl import mem_pkg::*; #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RAM2_TOP  = ADDR_W'(DEF_RAM2_TOP),
  parameter logic [ADDR_W-1:0] UART_BASE = ADDR_W'(DEF_UART_BASE),
  parameter int                WAIT_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              Ram1EN,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram2EN,
  output logic              Ram2OE,
  output logic              Ram2WE,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_data_oe_o,
  input  logic [DATA_W-1:0] ram1_data_i,
  input  logic [DATA_W-1:0] ram2_data_i,
  output logic              rdn,
  output logic              wrn,
  input  logic [7:0]        uart_data_i,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  target_t           target_q, target_d, dec_target;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic [DATA_W-1:0] rd_capture, wr_payload;
  logic              req_valid, active, strobing;

  mem_addr_decode #(
    .ADDR_W   (ADDR_W),
    .RAM2_TOP (RAM2_TOP),
    .UART_BASE(UART_BASE)
  ) u_decode (
    .addr_i  (addr_i),
    .target_o(dec_target)
  );

  assign req_valid = memread_i ^ memwrite_i;
  assign active    = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign strobing  = (state_q == ST_STROBE) || (state_q == ST_HOLD);

`ifdef MEM_CTRL_UART_EN
  always_comb begin
    case (target_q)
      TGT_RAM2:      rd_capture = ram2_data_i;
      TGT_UART_DATA: rd_capture = DATA_W'(uart_data_i);
      TGT_UART_STAT: rd_capture = {{(DATA_W-2){1'b0}}, data_ready, tbre & tsre};
      default:       rd_capture = ram1_data_i;
    endcase
  end
  // The UART only carries a byte; upper write bits are forced to zero.
  assign wr_payload = (dec_target == TGT_UART_DATA) ? DATA_W'(wdata_i[7:0]) : wdata_i;
  assign rdn = ~(strobing && !write_q && (target_q == TGT_UART_DATA));
  assign wrn = ~(strobing &&  write_q && (target_q == TGT_UART_DATA));
`else
  logic unused_uart;
  assign unused_uart = ^{uart_data_i, data_ready, tbre, tsre};
  assign rd_capture  = (target_q == TGT_RAM2) ? ram2_data_i : ram1_data_i;
  assign wr_payload  = wdata_i;
  assign rdn = 1'b1;
  assign wrn = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d    = ST_SETUP;
          target_d   = dec_target;
          write_d    = memwrite_i;
          ram_addr_d = addr_i;
          ram_data_d = wr_payload;
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        cnt_d = WAIT_INIT;
        if (WAIT_INIT == 3'd0) begin
          state_d = ST_DONE;
          if (!write_q) rdata_d = rd_capture;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Leaving when the count reaches zero keeps HOLD exactly WAIT_CYC cycles long.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_DONE;
          if (!write_q) rdata_d = rd_capture;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= TGT_RAM1;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign Ram1EN = ~(active && (target_q == TGT_RAM1));
  assign Ram1OE = ~(strobing && !write_q && (target_q == TGT_RAM1));
  assign Ram1WE = ~(strobing &&  write_q && (target_q == TGT_RAM1));
  assign Ram2EN = ~(active && (target_q == TGT_RAM2));
  assign Ram2OE = ~(strobing && !write_q && (target_q == TGT_RAM2));
  assign Ram2WE = ~(strobing &&  write_q && (target_q == TGT_RAM2));

  // Stall rises combinationally on an accepted request so the CPU holds that same cycle.
  assign stall_o       = active || ((state_q == ST_IDLE) && req_valid && rst);
  assign done_o        = (state_q == ST_DONE);
  assign ram_data_oe_o = active && write_q;
  assign rdata_o       = rdata_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_data_o    = ram_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Random + directed bench for mem_ctrl; three instances with WAIT_CYC = 0, 1, 7 share stimulus.
module tb_mem_ctrl;

  logic clk, rst;
  logic memread, memwrite;
  logic [15:0] addr, wdata, ram1_d, ram2_d;
  logic [7:0]  uart_d;
  logic data_ready, tbre, tsre;

  logic [15:0] rdata [3];
  logic [15:0] ram_addr [3];
  logic [15:0] ram_data [3];
  logic [2:0] stall, done, Ram1EN, Ram1OE, Ram1WE, Ram2EN, Ram2OE, Ram2WE, oe, rdn, wrn;

  int n_chk = 0;
  int n_fail = 0;
  int dir_id = 0;

  // Model state, one slot per instance
  int t [3];
  logic m_wr [3];
  int m_tg [3];
  logic [15:0] exp_rd [3];
  logic [15:0] exp_ad [3];
  logic [15:0] exp_wd [3];
  logic watch [3];
  int lat [3];
  int c_en1 [3];
  int c_en2 [3];
  int c_we2 [3];
  int c_oe1 [3];
  int c_stb [3];

  // Hand-computed per-instance literals (W = 0, 1, 7): latency, RAM EN-low cycles, strobe-low cycles
  int LAT_LIT [3] = '{3, 4, 10};
  int ENC_LIT [3] = '{2, 3, 9};
  int STC_LIT [3] = '{1, 2, 8};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_ctrl #(
      .DATA_W(16), .ADDR_W(16), .RAM2_TOP(16'hBEFF), .UART_BASE(16'hBF00),
      .WAIT_CYC(g == 0 ? 0 : (g == 1 ? 1 : 7))
    ) u_dut (
      .clk(clk), .rst(rst), .memread_i(memread), .memwrite_i(memwrite),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[g]), .stall_o(stall[g]),
      .done_o(done[g]), .Ram1EN(Ram1EN[g]), .Ram1OE(Ram1OE[g]), .Ram1WE(Ram1WE[g]),
      .Ram2EN(Ram2EN[g]), .Ram2OE(Ram2OE[g]), .Ram2WE(Ram2WE[g]),
      .ram_addr_o(ram_addr[g]), .ram_data_o(ram_data[g]), .ram_data_oe_o(oe[g]),
      .ram1_data_i(ram1_d), .ram2_data_i(ram2_d), .rdn(rdn[g]), .wrn(wrn[g]),
      .uart_data_i(uart_d), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waits(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 7);
  endfunction

  // 0 = RAM1, 1 = RAM2, 2 = UART data, 3 = UART status
  function automatic int tgt_of(input logic [15:0] a);
    if (a <= 16'hBEFF) return 1;
`ifdef MEM_CTRL_UART_EN
    if (a == 16'hBF00) return 2;
    if (a == 16'hBF01) return 3;
`endif
    return 0;
  endfunction

  task automatic chk1(input string nm, input int i, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s W=%0d @%0t: got %b want %b", nm, waits(i), $time, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s W=%0d @%0t: got %h want %h", nm, waits(i), $time, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s W=%0d @%0t: got %0d want %0d", nm, waits(i), $time, act, exp);
    end
  endtask

  // Compare process: checks every output of every instance at each falling edge
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      int len, tt;
      logic act, stb, rd_now, wr_now, req;
      len = 3 + waits(i);
      if (!rst) begin
        t[i] = 0; exp_rd[i] = '0; exp_ad[i] = '0; exp_wd[i] = '0; watch[i] = 1'b0;
      end
      tt = t[i];
      act = (tt >= 1) && (tt <= len - 1);
      stb = (tt >= 2) && (tt <= len - 1);
      rd_now = stb && !m_wr[i];
      wr_now = stb && m_wr[i];
      req = rst && (memread ^ memwrite);
      chk1("Ram1EN", i, Ram1EN[i], !(act && m_tg[i] == 0));
      chk1("Ram2EN", i, Ram2EN[i], !(act && m_tg[i] == 1));
      chk1("Ram1OE", i, Ram1OE[i], !(rd_now && m_tg[i] == 0));
      chk1("Ram1WE", i, Ram1WE[i], !(wr_now && m_tg[i] == 0));
      chk1("Ram2OE", i, Ram2OE[i], !(rd_now && m_tg[i] == 1));
      chk1("Ram2WE", i, Ram2WE[i], !(wr_now && m_tg[i] == 1));
      chk1("rdn", i, rdn[i], !(rd_now && m_tg[i] == 2));
      chk1("wrn", i, wrn[i], !(wr_now && m_tg[i] == 2));
      chk1("data_oe", i, oe[i], act && m_wr[i]);
      chk1("stall", i, stall[i], act || (tt == 0 && req));
      chk1("done", i, done[i], tt == len);
      chk16("rdata", i, rdata[i], exp_rd[i]);
      chk16("ram_addr", i, ram_addr[i], exp_ad[i]);
      chk16("ram_data", i, ram_data[i], exp_wd[i]);

      if (dir_id == 4 && !rst) begin
        chk1("rst_we2_lit", i, Ram2WE[i], 1'b1);
        chk1("rst_en2_lit", i, Ram2EN[i], 1'b1);
        chk1("rst_stall_lit", i, stall[i], 1'b0);
      end
      if (dir_id == 5 && memread && memwrite) chk1("both_stall_lit", i, stall[i], 1'b0);

      if (rst && watch[i]) begin
        lat[i]++;
        if (!Ram1EN[i]) c_en1[i]++;
        if (!Ram2EN[i]) c_en2[i]++;
        if (!Ram2WE[i]) c_we2[i]++;
        if (!Ram1OE[i]) c_oe1[i]++;
        if (!(Ram1OE[i] && Ram1WE[i] && Ram2OE[i] && Ram2WE[i] && rdn[i] && wrn[i])) c_stb[i]++;
        if (done[i]) begin
          watch[i] = 1'b0;
          case (dir_id)
            1: begin
              chki("wr_latency", i, lat[i], LAT_LIT[i]);
              chki("wr_en2_cycles", i, c_en2[i], ENC_LIT[i]);
              chki("wr_we2_cycles", i, c_we2[i], STC_LIT[i]);
              chki("wr_en1_cycles", i, c_en1[i], 0);
            end
            2: begin
              chk16("rd_ram1_lit", i, rdata[i], 16'hABCD);
              chki("rd_oe1_cycles", i, c_oe1[i], STC_LIT[i]);
              chki("rd_latency", i, lat[i], LAT_LIT[i]);
            end
            3: begin
`ifdef MEM_CTRL_UART_EN
              chk16("stat_lit", i, rdata[i], 16'h0002);
              chki("stat_en_cycles", i, c_en1[i] + c_en2[i], 0);
              chki("stat_stb_cycles", i, c_stb[i], 0);
`else
              chk16("stat_as_ram1_lit", i, rdata[i], 16'h5A5A);
              chki("stat_en1_cycles", i, c_en1[i], ENC_LIT[i]);
`endif
            end
            default: ;
          endcase
        end
      end

      if (rst) begin
        if (t[i] == 0) begin
          if (memread ^ memwrite) begin
            t[i] = 1;
            m_wr[i] = memwrite;
            m_tg[i] = tgt_of(addr);
            exp_ad[i] = addr;
            exp_wd[i] = (m_tg[i] == 2) ? {8'h00, wdata[7:0]} : wdata;
            watch[i] = 1'b1;
            lat[i] = 0; c_en1[i] = 0; c_en2[i] = 0; c_we2[i] = 0; c_oe1[i] = 0; c_stb[i] = 0;
          end
        end else if (t[i] == len) begin
          t[i] = 0;
        end else begin
          if (t[i] == len - 1 && !m_wr[i]) begin
            case (m_tg[i])
              0: exp_rd[i] = ram1_d;
              1: exp_rd[i] = ram2_d;
              2: exp_rd[i] = {8'h00, uart_d};
              default: exp_rd[i] = {14'h0, data_ready, tbre & tsre};
            endcase
          end
          t[i]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input int id, input logic rd, input logic [15:0] a, input logic [15:0] wd);
    dir_id = id;
    memread = rd; memwrite = !rd; addr = a; wdata = wd;
    step();
    memread = 1'b0; memwrite = 1'b0;
    repeat (12) step();
    dir_id = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      t[i] = 0; m_wr[i] = 1'b0; m_tg[i] = 0; watch[i] = 1'b0;
      exp_rd[i] = '0; exp_ad[i] = '0; exp_wd[i] = '0;
      lat[i] = 0; c_en1[i] = 0; c_en2[i] = 0; c_we2[i] = 0; c_oe1[i] = 0; c_stb[i] = 0;
    end
    rst = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    ram1_d = '0; ram2_d = '0; uart_d = '0; data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    directed(1, 1'b0, 16'h4000, 16'h1234);
    ram1_d = 16'hABCD;
    directed(2, 1'b1, 16'hC000, 16'h0000);
    ram1_d = 16'h5A5A; data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
    directed(3, 1'b1, 16'hBF01, 16'h0000);
    uart_d = 8'hC3;
    directed(0, 1'b1, 16'hBF00, 16'h0000);
    directed(0, 1'b0, 16'hBF00, 16'hFE77);

    dir_id = 5; memread = 1'b1; memwrite = 1'b1; addr = 16'h4000;
    repeat (3) step();
    memread = 1'b0; memwrite = 1'b0; dir_id = 0;
    step();

    // Abort a write in STROBE with an asynchronous reset, then read normally
    dir_id = 4; memwrite = 1'b1; addr = 16'h4000; wdata = 16'h1234;
    step();
    memwrite = 1'b0;
    step();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1; dir_id = 0;
    ram1_d = 16'hABCD;
    directed(2, 1'b1, 16'hC000, 16'h0000);

    for (int k = 0; k < 800; k++) begin
      int r;
      r = int'($urandom_range(0, 15));
      memread  = (r < 4) || (r == 8);
      memwrite = (r >= 4 && r < 8) || (r == 8);
      case ($urandom_range(0, 6))
        0: addr = 16'hBF00;
        1: addr = 16'hBF01;
        2: addr = 16'hBEFF;
        3: addr = 16'hBF02;
        4: addr = 16'($urandom_range(16'hBF02, 16'hFFFF));
        default: addr = 16'($urandom_range(0, 16'hBEFF));
      endcase
      wdata = 16'($urandom);
      ram1_d = 16'($urandom);
      ram2_d = 16'($urandom);
      uart_d = 8'($urandom);
      data_ready = 1'($urandom);
      tbre = 1'($urandom);
      tsre = 1'($urandom);
      rst = ($urandom_range(0, 149) != 0);
      step();
    end
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0;
    repeat (14) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
